// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (signed/unsigned, 32-bit operands).
// Responds to the execute stage's start/ready handshake and returns {remainder, quotient}.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 cpu_clk_50M,
  input  logic                 cpu_rst_n,
  input  logic                 div_start_i,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     div_opdata1_i,
  input  logic [WIDTH-1:0]     div_opdata2_i,
  input  logic                 annul_i,
  output logic                 div_ready_o,
  output logic                 div_busy_o,
  output logic [2*WIDTH-1:0]   divres_o,
  output logic                 div_by_zero_o
);

  localparam logic [1:0] S_FREE    = 2'd0;
  localparam logic [1:0] S_BY_ZERO = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_END     = 2'd3;
  localparam logic [5:0] CNT_LAST  = 6'(WIDTH);

  logic [1:0]         state_q,  state_d;
  logic [5:0]         cnt_q,    cnt_d;
  logic [WIDTH-1:0]   op1_raw_q, op1_raw_d;
  logic [WIDTH-1:0]   op2_mag_q, op2_mag_d;
  logic               q_neg_q,  q_neg_d;
  logic               r_neg_q,  r_neg_d;
  logic [2*WIDTH:0]   shreg_q,  shreg_d;
  logic [2*WIDTH-1:0] divres_q, divres_d;
  logic               ready_q,  ready_d;
  logic               dbz_q,    dbz_d;

  logic [WIDTH-1:0]   op1_mag_s;
  logic [WIDTH-1:0]   op2_mag_s;
  logic [2*WIDTH:0]   shifted_s;
  logic [WIDTH+1:0]   diff_s;
  logic [2*WIDTH:0]   step_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  // Operand magnitudes, one restoring step and final sign correction.
  always_comb begin
    op1_mag_s = (signed_div_i && div_opdata1_i[WIDTH-1]) ? ({WIDTH{1'b0}} - div_opdata1_i)
                                                         : div_opdata1_i;
    op2_mag_s = (signed_div_i && div_opdata2_i[WIDTH-1]) ? ({WIDTH{1'b0}} - div_opdata2_i)
                                                         : div_opdata2_i;
    shifted_s = shreg_q << 1;
    diff_s    = {1'b0, shifted_s[2*WIDTH:WIDTH]} - {2'b00, op2_mag_q};
    if (!diff_s[WIDTH+1]) begin
      step_s = {diff_s[WIDTH:0], shifted_s[WIDTH-1:1], 1'b1};
    end else begin
      step_s = {shifted_s[2*WIDTH:1], 1'b0};
    end
    quo_fix_s = q_neg_q ? ({WIDTH{1'b0}} - shreg_q[WIDTH-1:0]) : shreg_q[WIDTH-1:0];
    rem_fix_s = r_neg_q ? ({WIDTH{1'b0}} - shreg_q[2*WIDTH-1:WIDTH])
                        : shreg_q[2*WIDTH-1:WIDTH];
  end

  // State register.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= S_FREE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; annul overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (annul_i) begin
      state_d = S_FREE;
    end else begin
      case (state_q)
        S_FREE: begin
          if (div_start_i) begin
            state_d = (div_opdata2_i == {WIDTH{1'b0}}) ? S_BY_ZERO : S_ON;
          end else begin
            state_d = S_FREE;
          end
        end
        S_BY_ZERO: state_d = S_END;
        S_ON: begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_END;
          end else begin
            state_d = S_ON;
          end
        end
        S_END: begin
          if (!div_start_i) begin
            state_d = S_FREE;
          end else begin
            state_d = S_END;
          end
        end
        default: state_d = S_FREE;
      endcase
    end
  end

  // Datapath and registered-output next values.
  always_comb begin
    cnt_d     = cnt_q;
    op1_raw_d = op1_raw_q;
    op2_mag_d = op2_mag_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    shreg_d   = shreg_q;
    divres_d  = divres_q;
    ready_d   = ready_q;
    dbz_d     = dbz_q;
    if (annul_i) begin
      divres_d = {2*WIDTH{1'b0}};
      ready_d  = 1'b0;
      dbz_d    = 1'b0;
    end else begin
      case (state_q)
        S_FREE: begin
          if (div_start_i) begin
            op1_raw_d = div_opdata1_i;
            op2_mag_d = op2_mag_s;
            q_neg_d   = signed_div_i && (div_opdata1_i[WIDTH-1] ^ div_opdata2_i[WIDTH-1]);
            r_neg_d   = signed_div_i && div_opdata1_i[WIDTH-1];
            shreg_d   = {{(WIDTH+1){1'b0}}, op1_mag_s};
            cnt_d     = 6'd0;
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_BY_ZERO: begin
          divres_d = {op1_raw_q, {WIDTH{1'b1}}};
          ready_d  = 1'b1;
          dbz_d    = 1'b1;
        end
        S_ON: begin
          if (cnt_q == CNT_LAST) begin
            divres_d = {rem_fix_s, quo_fix_s};
            ready_d  = 1'b1;
            dbz_d    = 1'b0;
          end else begin
            shreg_d = step_s;
            cnt_d   = cnt_q + 6'd1;
          end
        end
        S_END: begin
          if (!div_start_i) begin
            divres_d = {2*WIDTH{1'b0}};
            ready_d  = 1'b0;
            dbz_d    = 1'b0;
          end else begin
            ready_d = ready_q;
          end
        end
        default: begin
          divres_d = {2*WIDTH{1'b0}};
          ready_d  = 1'b0;
          dbz_d    = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      cnt_q     <= 6'd0;
      op1_raw_q <= {WIDTH{1'b0}};
      op2_mag_q <= {WIDTH{1'b0}};
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      shreg_q   <= {(2*WIDTH+1){1'b0}};
      divres_q  <= {2*WIDTH{1'b0}};
      ready_q   <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      op1_raw_q <= op1_raw_d;
      op2_mag_q <= op2_mag_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      shreg_q   <= shreg_d;
      divres_q  <= divres_d;
      ready_q   <= ready_d;
      dbz_q     <= dbz_d;
    end
  end

  assign div_ready_o   = ready_q;
  assign divres_o      = divres_q;
  assign div_by_zero_o = dbz_q;
  assign div_busy_o    = (state_q != S_FREE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sgn;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        annul;
  logic        ready;
  logic        busy;
  logic [63:0] divres;
  logic        dbz;

  int vectors;
  int miscompares;

  div_unit #(.WIDTH(32)) dut (
    .cpu_clk_50M  (clk),
    .cpu_rst_n    (rst_n),
    .div_start_i  (start),
    .signed_div_i (sgn),
    .div_opdata1_i(op1),
    .div_opdata2_i(op2),
    .annul_i      (annul),
    .div_ready_o  (ready),
    .div_busy_o   (busy),
    .divres_o     (divres),
    .div_by_zero_o(dbz)
  );

  always #5 clk = ~clk;

  // Returns {div_by_zero, remainder, quotient} from plain arithmetic.
  function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic signed [31:0] sa, sb, sq, sr;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      return {1'b1, a, 32'hFFFF_FFFF};
    end
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        sa = a;
        sb = b;
        sq = sa / sb;
        sr = sa % sb;
        q  = sq;
        r  = sr;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, r, q};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input string tag);
    logic [64:0] exp;
    int n;
    bit got;
    exp = ref_div(a, b, s);
    @(negedge clk);
    start = 1'b1;
    op1   = a;
    op2   = b;
    sgn   = s;
    n     = 0;
    got   = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      #1;
      n++;
      op1 = $urandom;
      op2 = $urandom;
      sgn = 1'($urandom_range(0, 1));
      if (ready === 1'b1) got = 1'b1;
    end
    chk({tag, "_lat"}, 64'(n), (b == 32'd0) ? 64'd2 : 64'd34);
    chk({tag, "_res"}, divres, exp[63:0]);
    chk({tag, "_dbz"}, 64'(dbz), 64'(exp[64]));
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    chk({tag, "_hold"}, {63'd0, ready} ^ divres, {63'd0, 1'b1} ^ exp[63:0]);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_drop"}, {divres[61:0], ready, busy}, 64'd0);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; sgn = 1'b0;
    op1 = 32'd0; op2 = 32'd0; annul = 1'b0;
    vectors = 0; miscompares = 0;

    #12;
    chk("reset_outs", {divres[60:0], ready, busy, dbz}, 64'd0);
    chk("reset_res_hi", divres, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_div(32'd7,          32'd2,          1'b1, "s_7_2");
    do_div(32'hFFFF_FFF9,  32'd2,          1'b1, "s_m7_2");
    do_div(32'd7,          32'hFFFF_FFFE,  1'b1, "s_7_m2");
    do_div(32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, "s_m7_m2");
    do_div(32'hFFFF_FFFF,  32'h10,         1'b0, "u_ff_16");
    do_div(32'hFFFF_FFFF,  32'h10,         1'b1, "s_m1_16");
    do_div(32'h1234,       32'd0,          1'b0, "by_zero");
    do_div(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, "overflow");
    do_div(32'hFFFF_FFFF,  32'd1,          1'b0, "u_max_1");
    do_div(32'd3,          32'hFFFF_FFFF,  1'b0, "u_small_big");

    // Abort after iteration 10, then a fresh operation.
    @(negedge clk);
    start = 1'b1; op1 = 32'd12345; op2 = 32'd5; sgn = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk);
    #1;
    chk("annul_state", {62'd0, busy, ready}, 64'd0);
    annul = 1'b0;
    start = 1'b0;
    do_div(32'd100, 32'd7, 1'b1, "after_annul");

    // Asynchronous reset in the middle of ON.
    @(negedge clk);
    start = 1'b1; op1 = 32'd999; op2 = 32'd3; sgn = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_on", {divres[60:0], ready, busy, dbz}, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while a result is being held.
    @(negedge clk);
    start = 1'b1; op1 = 32'd1000; op2 = 32'd7; sgn = 1'b0;
    repeat (36) @(posedge clk);
    #2;
    chk("pre_rst_end", divres, 64'h0000_0006_0000_008E);
    rst_n = 1'b0;
    #1;
    chk("rst_in_end", {divres[60:0], ready, busy, dbz}, 64'd0);
    chk("rst_in_end_hi", divres, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      int sel;
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel < 4) rb = $urandom_range(1, 20);
      else if (sel < 6) rb = 32'hFFFF_FFFF - $urandom_range(0, 20);
      else rb = $urandom;
      do_div(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit integer divider; the responder side of the divide start/ready handshake issued by the execute stage.
- Execute raises div_start_i together with the operands and the signedness flag. It stalls the pipeline until div_ready_o rises, then consumes divres_o.
- Radix-2 restoring algorithm, one quotient bit per cycle. Supports signed (DIV) and unsigned (DIVU).

Parameters:
- WIDTH, 32, operand width. Only 32 is supported and verified; the result is 2*WIDTH.

Ports:
- cpu_clk_50M  in  1  system clock, rising edge.
- cpu_rst_n  in  1  reset, asynchronous, active-low.
- div_start_i  in  1  request. Held high by the requester until it has seen div_ready_o.
- signed_div_i  in  1  1 = signed divide, 0 = unsigned. Sampled with the operands.
- div_opdata1_i  in  32  dividend.
- div_opdata2_i  in  32  divisor.
- annul_i  in  1  abort the current operation (exception/flush). Synchronous.
- div_ready_o  in→out  1  result valid (output).
- div_busy_o  out  1  high in any state other than FREE.
- divres_o  out  64  {remainder[63:32], quotient[31:0]}. Loaded into HI/LO by the requester.
- div_by_zero_o  out  1  qualifies divres_o when the divisor was 0.

Behaviour:
- Reset values: state=FREE, div_ready_o=0, div_busy_o=0, divres_o=0, div_by_zero_o=0, counter=0, internal operand registers=0.
- Reset asserted mid-operation aborts immediately with no partial result.
- States: FREE, BY_ZERO, ON, END.
- FREE:
  - If div_start_i=1 and annul_i=0, latch operands and signedness at this edge (E0).
  - Divisor 0 → go to BY_ZERO. Otherwise go to ON.
  - When latching, form the magnitudes: if signed and the operand's MSB=1, store its two's-complement negation, else store it unchanged.
  - Clear the 65-bit partial-remainder/quotient shift register {33'b0, |op1|} and set cnt=0.
- ON:
  - Edges E1..E32 each perform one restoring step. Shift left by 1, trial-subtract |op2| from the upper 33 bits.
  - If the difference is non-negative, keep it and set quotient LSB=1. Otherwise restore and set LSB=0. Increment cnt.
  - At edge E33 (cnt==32), apply sign correction:
    - Quotient is negated if signed and op1[31]^op2[31].
    - Remainder is negated if signed and op1[31]=1 (remainder takes the dividend's sign).
  - Also at E33: load divres_o, set div_ready_o=1, go to END.
  - Latency: div_ready_o is first high in the cycle after E33, i.e. 34 cycles after start is first sampled.
- BY_ZERO: at the next edge (E1) go to END with div_ready_o=1, div_by_zero_o=1, divres_o={op1 as given, 32'hFFFF_FFFF}.
- END:
  - Hold div_ready_o, divres_o and div_by_zero_o stable while div_start_i=1.
  - On the first edge with div_start_i=0: go to FREE and clear div_ready_o, divres_o and div_by_zero_o to 0.
  - A new start cannot be accepted in the same edge that leaves END. At least one FREE cycle is required.
- Operand inputs are ignored outside the FREE accept edge. Changes during ON do not affect the result.
- div_start_i pulses while busy are ignored.
- annul_i=1 at any edge, from any state:
  - Go to FREE and clear div_ready_o, divres_o and div_by_zero_o.
  - annul has priority over start and over completion in the same edge.
- Overflow: signed 0x8000_0000 / 0xFFFF_FFFF yields quotient 0x8000_0000 and remainder 0 (natural two's-complement wrap, no flag).
- div_busy_o = (state != FREE), combinational from the state register.

Test Plan:
- Signed 7 / 2: start held → div_ready_o rises 34 cycles after start, divres_o=0x00000001_00000003. Drop start → ready=0 and divres_o=0 the next cycle.
- Signed sign cases:
  - -7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
  - -7 / -2 → quotient 3, remainder 0xFFFFFFFF.
- Unsigned 0xFFFFFFFF / 0x10 → quotient 0x0FFFFFFF, remainder 0xF. The same operands signed → quotient 0, remainder 0xFFFFFFFF.
- Divide by zero: op1=0x1234, op2=0 → ready 2 cycles after start, div_by_zero_o=1, divres_o=0x00001234_FFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Operands changed during ON → result unchanged.
- annul_i pulsed at iteration 10 → next cycle FREE with busy=0, ready=0. A new start of 100/7 then gives quotient 14, remainder 2 after 34 cycles. cpu_rst_n asserted mid-ON → all outputs 0 immediately, asynchronously.
